// File: rtl/rv_instr_encoder.sv
// ALU-control to RV32I R/I-type instruction encoder with a small valid/ready output FIFO.
// Define ENC_DROP_ILLEGAL_EN to count-and-discard illegal requests instead of queueing NOPs.
module rv_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_aluctrl,
  input  logic             req_alusrc,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [11:0]      req_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             instr_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d, ecnt_q, ecnt_d;
  logic [32:0]      enc;
  logic             push, pop, wr_en;

  // Returns {illegal, instruction word}; illegal requests become the canonical NOP.
  function automatic logic [32:0] encode(input logic [3:0] ctrl, input logic src,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [11:0] imm);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok, shift;
    f3 = 3'b000; f7 = 7'b0000000; ok = 1'b1; shift = 1'b0;
    case (ctrl)
      4'b0010: f3 = 3'b000;
      4'b0110: begin f3 = 3'b000; f7 = 7'b0100000; ok = !src; end
      4'b0000: f3 = 3'b111;
      4'b0001: f3 = 3'b110;
      4'b0011: f3 = 3'b100;
      4'b0111: begin f3 = 3'b001; shift = 1'b1; end
      4'b1011: begin f3 = 3'b101; shift = 1'b1; end
      4'b1111: begin f3 = 3'b101; f7 = 7'b0100000; shift = 1'b1; end
      4'b1110: f3 = 3'b010;
      default: ok = 1'b0;
    endcase
    if (!ok)   return {1'b1, 32'h0000_0013};
    if (!src)  return {1'b0, f7, rs2, rs1, f3, rd, 7'b0110011};
    if (shift) return {1'b0, f7, imm[4:0], rs1, f3, rd, 7'b0010011};
    return {1'b0, imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign enc         = encode(req_aluctrl, req_alusrc, req_rd, req_rs1, req_rs2, req_imm);
  assign req_ready   = (cnt_q != FULL_CNT);
  assign instr_valid = (cnt_q != '0);
  assign push        = req_valid && req_ready && !flush;
  assign pop         = instr_valid && instr_ready && !flush;
  assign instr       = mem_q[rd_ptr_q];
  assign instr_cnt   = icnt_q;
  assign err_cnt     = ecnt_q;

`ifdef ENC_DROP_ILLEGAL_EN
  assign wr_en     = push && !enc[32];
  assign instr_err = 1'b0;
`else
  logic [DEPTH-1:0] err_q;
  assign wr_en     = push;
  assign instr_err = err_q[rd_ptr_q];
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    icnt_d   = icnt_q;
    ecnt_d   = ecnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (pop)             icnt_d = sat_inc(icnt_q);
      if (push && enc[32]) ecnt_d = sat_inc(ecnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      icnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      icnt_q   <= icnt_d;
      ecnt_q   <= ecnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifndef ENC_DROP_ILLEGAL_EN
      err_q <= '0;
`endif
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= enc[31:0];
`ifndef ENC_DROP_ILLEGAL_EN
      err_q[wr_ptr_q] <= enc[32];
`endif
    end
  end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Randomized and directed bench for rv_instr_encoder with a queue-based reference model.
// Honours ENC_DROP_ILLEGAL_EN the same way as the design.
module tb_rv_instr_encoder;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef ENC_DROP_ILLEGAL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, flush, req_valid, req_ready, req_alusrc;
  logic [3:0]       req_aluctrl;
  logic [4:0]       req_rd, req_rs1, req_rs2;
  logic [11:0]      req_imm;
  logic             instr_valid, instr_ready, instr_err;
  logic [31:0]      instr;
  logic [CNT_W-1:0] instr_cnt, err_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] q[$];
  int m_icnt = 0;
  int m_ecnt = 0;
  int saved;
  logic [3:0] legal_codes [9] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd7, 4'd11, 4'd15, 4'd14};

  rv_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluctrl(req_aluctrl),
    .req_alusrc(req_alusrc), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_err(instr_err), .instr_cnt(instr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32I field placement computed arithmetically from the mnemonic table.
  function automatic logic [32:0] model_enc(input logic [3:0] c, input logic s, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [11:0] imm);
    longint w;
    int f3;
    bit legal, alt, shift;
    legal = 1; alt = 0; shift = 0; f3 = 0;
    case (int'(c))
      2:  f3 = 0;
      6:  begin f3 = 0; alt = 1; legal = !s; end
      0:  f3 = 7;
      1:  f3 = 6;
      3:  f3 = 4;
      7:  begin f3 = 1; shift = 1; end
      11: begin f3 = 5; shift = 1; end
      15: begin f3 = 5; shift = 1; alt = 1; end
      14: f3 = 2;
      default: legal = 0;
    endcase
    if (!legal) return {1'b1, 32'h13};
    w = longint'(rd) * 128 + longint'(rs1) * (1 << 15) + longint'(f3) * (1 << 12);
    if (!s)         w += 'h33 + longint'(rs2) * (1 << 20) + longint'(alt) * (1 << 30);
    else if (shift) w += 'h13 + longint'(imm % 32) * (1 << 20) + longint'(alt) * (1 << 30);
    else            w += 'h13 + longint'(imm) * (1 << 20);
    return {1'b0, w[31:0]};
  endfunction

  task automatic set_req(input logic [3:0] c, input logic s, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    req_aluctrl = c; req_alusrc = s; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  task automatic rand_req(input bit allow_illegal);
    logic [3:0] c;
    logic s;
    c = legal_codes[$urandom_range(8, 0)];
    s = 1'($urandom_range(1, 0));
    if (allow_illegal && $urandom_range(3, 0) == 0) c = 4'($urandom_range(15, 0));
    if (!allow_illegal && c == 4'd6) s = 1'b0;
    set_req(c, s, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
  endtask

  // Check state against the model, advance the model by one edge, then step the clock.
  task automatic tick();
    logic [32:0] e;
    bit mpush, mpop;
    chk("req_ready", 64'(req_ready), 64'(q.size() < DEPTH));
    chk("instr_valid", 64'(instr_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("instr", 64'(instr), 64'(q[0][31:0]));
      chk("instr_err", 64'(instr_err), 64'(q[0][32]));
    end
    chk("instr_cnt", 64'(instr_cnt), 64'(m_icnt));
    chk("err_cnt", 64'(err_cnt), 64'(m_ecnt));
    e = model_enc(req_aluctrl, req_alusrc, req_rd, req_rs1, req_rs2, req_imm);
    mpush = req_valid && (q.size() < DEPTH);
    mpop  = instr_ready && (q.size() > 0);
    if (flush) q.delete();
    else begin
      if (mpop) begin
        void'(q.pop_front());
        if (m_icnt < MAXC) m_icnt++;
      end
      if (mpush) begin
        if (e[32] && m_ecnt < MAXC) m_ecnt++;
        if (!(DROP && e[32])) q.push_back(DROP ? {1'b0, e[31:0]} : e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; instr_ready = 1'b0;
    set_req(4'd2, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    #12;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_icnt", 64'(instr_cnt), 64'd0);
    chk("rst_ecnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD then SUB, consumer always ready
    instr_ready = 1'b1; req_valid = 1'b1;
    set_req(4'b0010, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("add_latency", 64'(instr_valid), 64'd0);
    tick();
    chk("add_valid", 64'(instr_valid), 64'd1);
    chk("add_enc", 64'(instr), 64'h002081B3);
    set_req(4'b0110, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0);
    tick();
    chk("sub_enc", 64'(instr), 64'h407302B3);
    req_valid = 1'b0;
    tick();
    chk("add_sub_cnt", 64'(instr_cnt), 64'd2);

    req_valid = 1'b1;
    set_req(4'b0010, 1'b1, 5'd1, 5'd0, 5'd0, 12'hFFF);
    tick();
    chk("addi_enc", 64'(instr), 64'hFFF00093);
    set_req(4'b1111, 1'b1, 5'd4, 5'd4, 5'd0, 12'h003);
    tick();
    chk("srai_enc", 64'(instr), 64'h40325213);
    req_valid = 1'b0;
    tick();

    // Two illegal requests held in the FIFO
    instr_ready = 1'b0; req_valid = 1'b1;
    set_req(4'b0100, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    tick();
    set_req(4'b0110, 1'b1, 5'd1, 5'd2, 5'd3, 12'd5);
    tick();
    req_valid = 1'b0;
    chk("illegal_ecnt", 64'(err_cnt), 64'd2);
    if (DROP) chk("illegal_drop", 64'(instr_valid), 64'd0);
    else begin
      chk("illegal_nop", 64'(instr), 64'h13);
      chk("illegal_err", 64'(instr_err), 64'd1);
    end
    instr_ready = 1'b1;
    tick(); tick(); tick();

    // Backpressure, stall, drain and wrap
    instr_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin rand_req(1'b0); tick(); end
    chk("full_ready", 64'(req_ready), 64'd0);
    rand_req(1'b0); tick();
    instr_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin rand_req(1'b0); tick(); end
    req_valid = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) tick();

    // Random traffic with illegal requests and occasional flush
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(1, 0));
      instr_ready = 1'($urandom_range(1, 0));
      flush = ($urandom_range(15, 0) == 0);
      rand_req(1'b1);
      tick();
    end
    flush = 1'b0; req_valid = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();

    // Flush beats concurrent push and pop
    instr_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin rand_req(1'b0); tick(); end
    saved = m_icnt;
    flush = 1'b1; instr_ready = 1'b1; rand_req(1'b0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_empty", 64'(instr_valid), 64'd0);
    chk("flush_icnt", 64'(instr_cnt), 64'(saved));
    tick();

    // Asynchronous reset in the middle of a cycle
    instr_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin rand_req(1'b0); tick(); end
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd1);
    chk("arst_instr", 64'(instr), 64'd0);
    chk("arst_icnt", 64'(instr_cnt), 64'd0);
    chk("arst_ecnt", 64'(err_cnt), 64'd0);
    q.delete(); m_icnt = 0; m_ecnt = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Counter saturation
    instr_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin rand_req(1'b0); tick(); end
    chk("icnt_sat", 64'(instr_cnt), 64'(MAXC));
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      set_req(4'b0100, 1'b0, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
      tick();
    end
    chk("ecnt_sat", 64'(err_cnt), 64'(MAXC));
    req_valid = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
